// File: rtl/des_key_schedule_ctrl.sv
// rtl/des_key_schedule_ctrl.sv - DES key schedule sequencer; optional key parity check under DES_KEY_PARITY_CHECK_EN
module des_key_schedule_ctrl #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [64:1] key,
  input  logic        subkey_ready,
  output logic [48:1] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  // Tables list source bit numbers in FIPS notation (bit 1 first).
  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  logic [1:0]  state_q, state_d;
  logic [28:1] c_q, c_d;
  logic [28:1] d_q, d_d;
  logic [3:0]  rnd_q, rnd_d;
  logic        dir_q, dir_d;

  logic [56:1] pc1_key;
  logic [56:1] cd_cur;
  logic        key_ok;
  logic [4:0]  enc_k;
  logic [4:0]  dec_k;

  // FIPS "left" moves bit i+1 into bit i; bit 1 is the LSB of these vectors.
  function automatic logic [28:1] rot_l(input logic [28:1] x, input logic by2);
    return by2 ? {x[2:1], x[28:3]} : {x[1], x[28:2]};
  endfunction

  function automatic logic [28:1] rot_r(input logic [28:1] x, input logic by2);
    return by2 ? {x[26:1], x[28:27]} : {x[27:1], x[28]};
  endfunction

  function automatic logic shift_is_one(input logic [4:0] k);
    return (k == 5'd1) || (k == 5'd2) || (k == 5'd9) || (k == 5'd16);
  endfunction

  for (genvar i = 1; i <= 56; i++) begin : g_pc1
    assign pc1_key[i] = key[PC1[i-1]];
  end

  assign cd_cur = {d_q, c_q};

  for (genvar i = 1; i <= 48; i++) begin : g_pc2
    assign subkey[i] = cd_cur[PC2[i-1]];
  end

  // Shift-table index used when stepping from subkey rnd to rnd+1.
  assign enc_k = {1'b0, rnd_q} + 5'd2;
  assign dec_k = 5'd16 - {1'b0, rnd_q};

`ifdef DES_KEY_PARITY_CHECK_EN
  logic [7:0] byte_odd;
  logic       parity_err_q, parity_err_d;

  for (genvar j = 0; j < 8; j++) begin : g_par
    assign byte_odd[j] = ^key[8*j+8:8*j+1];
  end

  assign key_ok = &byte_odd;

  // Latch the verdict of every start seen in IDLE; a good key clears it.
  always_comb begin
    parity_err_d = parity_err_q;
    if ((state_q == ST_IDLE) && start) begin
      parity_err_d = ~key_ok;
    end
  end

  // Parity error flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign key_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Next-state logic: load on start, rotate C/D on each accepted subkey.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    rnd_d   = rnd_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (start && key_ok) begin
          dir_d   = decrypt;
          rnd_d   = 4'd0;
          state_d = ST_ROUND;
          // Decrypt starts from CD16, which equals CD0 after a full 28-bit turn.
          if (decrypt) begin
            c_d = pc1_key[28:1];
            d_d = pc1_key[56:29];
          end else begin
            c_d = rot_l(pc1_key[28:1], 1'b0);
            d_d = rot_l(pc1_key[56:29], 1'b0);
          end
        end
      end
      ST_ROUND: begin
        if (subkey_ready) begin
          if (rnd_q == LAST_RND) begin
            state_d = ST_DONE;
          end else begin
            rnd_d = rnd_q + 4'd1;
            if (dir_q) begin
              c_d = rot_r(c_q, ~shift_is_one(dec_k));
              d_d = rot_r(d_q, ~shift_is_one(dec_k));
            end else begin
              c_d = rot_l(c_q, ~shift_is_one(enc_k));
              d_d = rot_l(d_q, ~shift_is_one(enc_k));
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      rnd_q   <= 4'd0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      rnd_q   <= rnd_d;
      dir_q   <= dir_d;
    end
  end

  assign subkey_valid = (state_q == ST_ROUND);
  assign done         = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign round        = rnd_q;

endmodule

// File: doc/des_key_schedule_ctrl.md
Name: des_key_schedule_ctrl

Overview:
- Sequences the DES key schedule for the round datapath.
- On `start`, applies PC-1 to the 64-bit key and holds the C/D halves in registers.
- Delivers the 16 round subkeys (PC-2 outputs) one per valid/ready handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Sits between the key input register and the round-function block.

Parameters:
- ROUNDS, 16, number of subkeys issued per schedule; fixed at 16 for DES, and no other value is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new schedule; sampled only in IDLE.
- decrypt  input  1  0 = issue K1..K16, 1 = issue K16..K1; sampled with start.
- key  input  64  key[n] = FIPS 46-3 bit n; sampled with start only.
- subkey_ready  input  1  round datapath accepts current subkey.
- subkey  output  48  subkey[n] = PC-2 output bit n of current C/D.
- subkey_valid  output  1  subkey is valid.
- round  output  4  index 0..15 of the subkey being offered, in issue order.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after the last handshake.
- parity_err  output  1  see Optional Feature.

Behaviour:
- State machine: IDLE, ROUND, DONE.
  - 28-bit registers C, D; 4-bit counter rnd; 1-bit dir register.
- Index convention: C = PC-1 output bits 1..28; D = PC-1 output bits 29..56.
- Reset (rst=1 at a clock edge):
  - state=IDLE; C=D=0; rnd=0; dir=0.
  - subkey_valid=0, done=0, busy=0, parity_err=0, round=0.
  - subkey = PC-2(0) = 0.
  - Reset wins over any other input in the same cycle.
  - Reset mid-schedule abandons it, with no done pulse.
- IDLE, start=1 at an edge:
  - dir <= decrypt; rnd <= 0; state <= ROUND.
  - dir=0: C,D <= each rotated left by 1 from PC-1(key), i.e. CD1.
  - dir=1: C,D <= PC-1(key) unrotated. CD16 equals CD0 because the total rotation is 28.
- ROUND:
  - subkey_valid=1; subkey = PC-2(C,D) combinational from registers; round=rnd.
  - Latency: start accepted at edge N; first subkey valid in cycle N+1.
- Handshake (subkey_valid & subkey_ready at an edge):
  - rnd=15: state <= DONE.
  - Otherwise rnd <= rnd+1, and the next C,D is computed for index i = rnd+1:
    - dir=0: rotate left by s(i+1).
    - dir=1: rotate right by s(16-i+1).
  - Shift table s(k): 1 for k in {1,2,9,16}, 2 otherwise.
  - C and D rotate independently as 28-bit words.
- Stalls: subkey_ready=0 holds C, D, rnd and subkey stable indefinitely; valid never drops.
- DONE: done=1, subkey_valid=0, busy=1 for exactly one cycle, then IDLE.
- start while busy is ignored; key/decrypt changes while busy have no effect.
- start in the same cycle as done (state DONE) is ignored. Earliest restart is the next cycle, in IDLE.
- Throughput: with ready tied high, 16 subkeys occupy 16 consecutive cycles. Full schedule is start to IDLE in 18 cycles.

Optional Feature:
- Macro: DES_KEY_PARITY_CHECK_EN.
- Defined:
  - At start in IDLE, each byte key[8j+8:8j+1] (j=0..7) must have odd parity.
  - On failure, the start is rejected: state stays IDLE, parity_err <= 1.
  - parity_err clears on the next accepted start or on rst.
- Undefined: no check; parity_err is tied to 0.

Test Plan:
- FIPS key 133457799BBCDFF1 (bit 1 = MSB of hex string, mapped to key[1]), decrypt=0, ready=1, start pulse -> valid cycles 1..16; round 0 subkey 1B02EFFC7072; round 15 subkey CB3D8B0E17F5; done pulse cycle 17; busy low cycle 18.
- Same key, decrypt=1 -> round 0 subkey CB3D8B0E17F5; round 15 subkey 1B02EFFC7072; intermediate subkeys are the encrypt sequence reversed.
- Encrypt run, ready toggled 1,0,0,1,... -> subkey/round frozen while ready=0; exactly 16 handshakes; single done pulse.
- rst asserted at round 7 -> next cycle valid=0, busy=0, subkey=0; a fresh start then gives round 0 = 1B02EFFC7072.
- start re-pulsed during round 3 and during DONE -> ignored; sequence and done timing unchanged; no second schedule begins.
- With DES_KEY_PARITY_CHECK_EN: key 0000000000000000 -> parity_err=1, busy stays 0; then key 0101010101010101 -> accepted, parity_err=0.
